ret_credit_fifo: RTL

- Terminal buffer for a fixed-latency, non-stallable compute pipeline whose sideband valid/tag travels through a delay line.
- Upstream issue logic may start a ray only while a guaranteed landing slot exists.
- Tracks in-flight items and grants issue credits; absorbs returning results in a FIFO.
- Presents results to the framebuffer writer over a valid/ready interface.

---
 rtl/ret_credit_fifo_pkg.sv | 31 +++
 rtl/ret_fifo_mem.sv | 33 +++
 rtl/ret_credit_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ret_credit_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ret_credit_fifo_pkg
// Purpose  : Shared types and constants for the credit-tracked return FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package ret_credit_fifo_pkg;

    // Default geometry for the tracer result path
    localparam int c_DEF_W     = 8;
    localparam int c_DEF_L     = 4;
    localparam int c_DEF_DEPTH = 8;

    // Control FSM: FLUSH swallows stale delay-line valids after reset
    typedef enum logic [0:0] {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Ceiling log2, usable in constant expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage : ret_credit_fifo_pkg
`default_nettype wire

// File: rtl/ret_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : ret_fifo_mem
// Purpose  : DEPTH x W distributed-RAM array, synchronous write port and
//            asynchronous (combinational) read port for fall-through reads.
// Revision : 1.0 - initial release
// ============================================================================
module ret_fifo_mem #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    // Storage has no reset: contents are only meaningful behind the pointers
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : ret_fifo_mem
`default_nettype wire

// File: rtl/ret_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ret_credit_fifo
// Purpose  : Terminal buffer for a fixed-latency, non-stallable pipeline.
//            Grants issue credits only while a landing slot is guaranteed,
//            tracks in-flight items, absorbs returns into a fall-through FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module ret_credit_fifo
    import ret_credit_fifo_pkg::*;
#(
    parameter  int W     = c_DEF_W,
    parameter  int L     = c_DEF_L,
    parameter  int DEPTH = c_DEF_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_issue_valid,
    output logic          o_issue_ready,
    input  logic          i_ret_valid,
    input  logic [W-1:0]  i_ret_data,
    output logic          o_out_valid,
    output logic [W-1:0]  o_out_data,
    input  logic          i_out_ready,
    output logic [AW:0]   o_count,
    output logic [AW:0]   o_inflight,
    output logic          o_err
);

    // Flush counter must hold the value L; keep at least one bit
    localparam int FW = (clog2(L + 1) < 1) ? 1 : clog2(L + 1);

    localparam logic [FW-1:0] c_FLUSH_LAST = FW'(L);
    localparam logic [AW:0]   c_DEPTH_CNT  = (AW + 1)'(DEPTH);
    localparam logic [AW+1:0] c_DEPTH_SUM  = (AW + 2)'(DEPTH);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [FW-1:0] r_flush_cnt;
    logic [FW-1:0] w_flush_nxt;
    logic          w_run;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   r_inflight;
    logic          r_err;

    logic [AW:0]   w_count_nxt;
    logic [AW:0]   w_inflight_nxt;
    logic [AW+1:0] w_sum;
    logic          w_issue_ready;
    logic          w_issue;
    logic          w_ret;
    logic          w_read;
    logic          w_write;
    logic          w_full;
    logic          w_inf_zero;
    logic          w_err_set;

    // FSM state and flush counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_nxt;
        end
    end

    // FSM next state: FLUSH lasts L+1 edges after reset release, RUN is terminal
    always_comb begin
        w_state_nxt = r_state;
        w_flush_nxt = r_flush_cnt;
        w_run       = 1'b0;
        case (r_state)
            ST_FLUSH: begin
                if (r_flush_cnt == c_FLUSH_LAST) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_flush_nxt = r_flush_cnt + FW'(1);
                end
            end
            ST_RUN: begin
                w_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_FLUSH;
            end
        endcase
    end

    // Credit check is one bit wider than the counters so the sum cannot wrap
    assign w_sum         = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_issue_ready = w_run & (w_sum < c_DEPTH_SUM);
    assign w_issue       = i_issue_valid & w_issue_ready;

    // Returns are ignored entirely while flushing stale delay-line contents
    assign w_ret      = w_run & i_ret_valid;
    assign w_read     = (r_count != '0) & i_out_ready;
    assign w_full     = (r_count == c_DEPTH_CNT);
    assign w_write    = w_ret & (~w_full | w_read);
    assign w_inf_zero = (r_inflight == '0);

    // Protocol violations: issue without credit, orphan return, overflow
    assign w_err_set = w_run & ((i_issue_valid & ~w_issue_ready) |
                                (i_ret_valid & w_inf_zero) |
                                (i_ret_valid & w_full & ~w_read));

    // Occupancy and in-flight next values; an orphan return never underflows
    always_comb begin
        w_count_nxt    = r_count;
        w_inflight_nxt = r_inflight;
        case ({w_write, w_read})
            2'b10:   w_count_nxt = r_count + (AW + 1)'(1);
            2'b01:   w_count_nxt = r_count - (AW + 1)'(1);
            default: w_count_nxt = r_count;
        endcase
        if (w_issue && !w_ret) begin
            w_inflight_nxt = r_inflight + (AW + 1)'(1);
        end else if (!w_issue && w_ret && !w_inf_zero) begin
            w_inflight_nxt = r_inflight - (AW + 1)'(1);
        end
    end

    // Pointer, counter and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count    <= w_count_nxt;
            r_inflight <= w_inflight_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    ret_fifo_mem #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_write),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_ret_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (o_out_data)
    );

    assign o_issue_ready = w_issue_ready;
    assign o_out_valid   = (r_count != '0);
    assign o_count       = r_count;
    assign o_inflight    = r_inflight;
    assign o_err         = r_err;

endmodule : ret_credit_fifo
`default_nettype wire
